pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 12: program-counter and address width.
REQ-002 Parameter DATA_W, default 16: AC/DR data width.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 t  in  8  one-hot timing signals T0..T7.
REQ-007 d  in  8  one-hot opcode decode D0..D7.
REQ-008 i_bit  in  1  instruction I bit.
REQ-009 e_flag  in  1  E flip-flop.
REQ-010 ac  in  DATA_W  accumulator.
REQ-011 dr  in  DATA_W  data register.
REQ-012 ir_b  in  12  IR[11:0] register-reference / IO select bits.
REQ-013 ar  in  ADDR_W  address register, the load source.
REQ-014 fgi, fgo  in  1 each  input and output flags.
REQ-015 r_int  in  1  interrupt-cycle flag.
REQ-016 stall  in  1  freeze request.
REQ-017 pc  out  ADDR_W  registered program counter.
REQ-018 pc_clr, pc_inr, pc_load  out  1 each  combinational strobes naming the action taken at the next edge.

Function
REQ-019 Fetch: when r_int=0 and T1=1, pc SHALL increment at the edge.
REQ-020 BUN: when D4 and T4 are 1, pc SHALL load ar; when D5 and T5 are 1 (BSA), pc SHALL load ar.
REQ-021 ISZ: when D6 and T6 are 1 and dr==0, pc SHALL increment.
REQ-022 Register-reference skips: D7, I=0, T3 SHALL increment pc when any enabled condition holds: ir_b[4] SPA with ac[DATA_W-1]=0; ir_b[3] SNA with ac[DATA_W-1]=1; ir_b[2] SZA with ac==0; ir_b[1] SZE with e_flag=0.
REQ-023 IO skips: D7, I=1, T3 SHALL increment pc on ir_b[9] with fgi=1 (SKI) or ir_b[8] with fgo=1 (SKO).
REQ-024 Priority SHALL be clr > load > inr; at most one strobe is asserted per cycle.
REQ-025 Increment SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-026 stall=1 SHALL hold pc and force all three strobes to 0, whatever the other inputs are.
REQ-027 Malformed one-hot t or d SHALL produce only the actions matching the asserted bits; the block adds no error detection.
REQ-028 The latency from a qualifying input to the pc update SHALL be exactly one edge.

Reset
REQ-029 While rst_n=0, pc SHALL be RESET_VEC and all strobes 0, independent of clk.
REQ-030 Reset deasserting mid-instruction SHALL resume from RESET_VEC on the first edge; no pending action survives reset.

Configuration
REQ-031 Macro PC_UNIT_INTR_EN, when defined, SHALL enable interrupt-cycle handling:
- r_int=1 with T0: pc holds.
- r_int=1 with T1: pc_clr asserts and pc becomes 0.
- r_int=1 with T2: pc increments to 1.
- r_int=1 suppresses the fetch increment.
REQ-032 When PC_UNIT_INTR_EN is undefined, r_int SHALL be present but ignored, and pc_clr SHALL be constant 0.

Structure
REQ-033 A shared package SHALL hold the timing and decode index constants (T0..T7, D0..D7), the ir_b bit positions for SPA/SNA/SZA/SZE/SKI/SKO, and an enum for the action type {HOLD, CLR, LOAD, INR}.
REQ-034 Sub-module pc_skip_eval SHALL contain the combinational skip-condition logic; pc_unit SHALL own the register and the priority logic.

Verification
REQ-035 Reset then T1 pulse: pc goes 0 -> 1; with pc=0xFFF and T1, pc becomes 0x000 (wrap).
REQ-036 BUN with ar=0x3A5 at D4T4: pc=0x3A5 after one edge and pc_load=1 for one cycle; the same with stall=1 leaves pc unchanged.
REQ-037 D7 T3 I=0 with ir_b=0x010 and ac=0x7FFF: pc+1. With ac=0x8000: no change. With ir_b=0x002, e_flag=0: pc+1.
REQ-038 ISZ at D6T6: dr=0x0000 gives pc+1; dr=0x0001 leaves pc unchanged. SKI with fgi=1 at D7 I=1 T3: pc+1.
REQ-039 With PC_UNIT_INTR_EN defined, r_int=1 over T0..T2 starting at pc=0x123: pc goes 0x123 -> 0x000 -> 0x001. Without the macro, pc_clr stays 0 throughout.
REQ-040 rst_n asserted asynchronously between edges during D5T5: pc=RESET_VEC immediately, and no load occurs after release.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: one-hot indices for the
// timing/decode vectors, IR select bit positions, and the PC action type.
// Imported by pc_unit and pc_skip_eval.
package pc_unit_pkg;

    // Timing signal indices (T0..T7)
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    // Opcode decode indices (D0..D7)
    localparam int D0 = 0;
    localparam int D1 = 1;
    localparam int D2 = 2;
    localparam int D3 = 3;
    localparam int D4 = 4;
    localparam int D5 = 5;
    localparam int D6 = 6;
    localparam int D7 = 7;

    // IR[11:0] select bits for register-reference and IO skips
    localparam int SPA_B = 4;
    localparam int SNA_B = 3;
    localparam int SZA_B = 2;
    localparam int SZE_B = 1;
    localparam int SKI_B = 9;
    localparam int SKO_B = 8;

    // What the PC does at the next edge
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_INR  = 2'd3
    } act_e;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of control inputs and PC outputs shared between the sequencer
// (master) and the program-counter unit (slave). Clock and reset stay
// outside the bundle as plain ports.
interface pc_unit_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [7:0]        t;
    logic [7:0]        d;
    logic              i_bit;
    logic              e_flag;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] dr;
    logic [11:0]       ir_b;
    logic [ADDR_W-1:0] ar;
    logic              fgi;
    logic              fgo;
    logic              r_int;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              pc_clr;
    logic              pc_inr;
    logic              pc_load;

    modport master (
        output t, d, i_bit, e_flag, ac, dr, ir_b, ar, fgi, fgo, r_int, stall,
        input  pc, pc_clr, pc_inr, pc_load
    );

    modport slave (
        input  t, d, i_bit, e_flag, ac, dr, ir_b, ar, fgi, fgo, r_int, stall,
        output pc, pc_clr, pc_inr, pc_load
    );
endinterface

// File: rtl/pc_skip_eval.sv
// Skip-condition evaluation: ISZ zero test, register-reference and IO skips.
// Latency: purely combinational, feeds the increment request of pc_unit.
// Backpressure: none; stall gating is applied by the owner of the register.
module pc_skip_eval
    import pc_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [7:0]        i_t,
    input  logic [7:0]        i_d,
    input  logic              i_ibit,
    input  logic              i_e_flag,
    input  logic [DATA_W-1:0] i_ac,
    input  logic [DATA_W-1:0] i_dr,
    input  logic [11:0]       i_ir_b,
    input  logic              i_fgi,
    input  logic              i_fgo,
    output logic              o_skip
);
    logic w_ac_neg;
    logic w_isz;
    logic w_rr_skip;
    logic w_io_skip;

    assign w_ac_neg = i_ac[DATA_W-1];

    // ISZ: skip when the incremented memory word (already in DR) is zero
    assign w_isz = i_d[D6] & i_t[T6] & (i_dr == '0);

    // Register-reference skips; several select bits may be set, any hit skips
    assign w_rr_skip = i_d[D7] & ~i_ibit & i_t[T3] &
                       ((i_ir_b[SPA_B] & ~w_ac_neg)     |
                        (i_ir_b[SNA_B] &  w_ac_neg)     |
                        (i_ir_b[SZA_B] & (i_ac == '0))  |
                        (i_ir_b[SZE_B] & ~i_e_flag));

    // IO skips on input/output flag ready
    assign w_io_skip = i_d[D7] & i_ibit & i_t[T3] &
                       ((i_ir_b[SKI_B] & i_fgi) | (i_ir_b[SKO_B] & i_fgo));

    assign o_skip = w_isz | w_rr_skip | w_io_skip;

    // Timing/decode/IR bits that never qualify a skip
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, i_t[T0], i_t[T1], i_t[T2], i_t[T4], i_t[T5], i_t[T7],
                             i_d[D0], i_d[D1], i_d[D2], i_d[D3], i_d[D4], i_d[D5],
                             i_ir_b[11:10], i_ir_b[7:5], i_ir_b[0]};
endmodule

// File: rtl/pc_unit.sv
// Program counter with clear/load/increment, priority clr > load > inr.
// Latency: one edge from qualifying timing/decode inputs to pc update.
// Backpressure: stall freezes pc and zeroes all strobes. Optional interrupt
// cycle handling is compiled in with PC_UNIT_INTR_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              ADDR_W    = 12,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              w_skip;
    logic              w_load_req;
    logic              w_inr_req;
    logic              w_clr_req;
    logic              w_fetch_inr;
    logic              w_intr_inr;
    act_e              w_act;

    pc_skip_eval #(
        .DATA_W (DATA_W)
    ) u_skip (
        .i_t      (bus.t),
        .i_d      (bus.d),
        .i_ibit   (bus.i_bit),
        .i_e_flag (bus.e_flag),
        .i_ac     (bus.ac),
        .i_dr     (bus.dr),
        .i_ir_b   (bus.ir_b),
        .i_fgi    (bus.fgi),
        .i_fgo    (bus.fgo),
        .o_skip   (w_skip)
    );

    // BUN at D4T4, BSA at D5T5 both jump to AR
    assign w_load_req = (bus.d[D4] & bus.t[T4]) | (bus.d[D5] & bus.t[T5]);

`ifdef PC_UNIT_INTR_EN
    // Interrupt cycle: T0 holds, T1 clears, T2 increments; fetch is suppressed
    assign w_fetch_inr = ~bus.r_int & bus.t[T1];
    assign w_clr_req   =  bus.r_int & bus.t[T1];
    assign w_intr_inr  =  bus.r_int & bus.t[T2];
`else
    // Interrupt flag is ignored; fetch always increments at T1
    assign w_fetch_inr = bus.t[T1];
    assign w_clr_req   = 1'b0;
    assign w_intr_inr  = 1'b0;
    logic w_unused_rint;
    assign w_unused_rint = bus.r_int;
`endif

    assign w_inr_req = w_fetch_inr | w_intr_inr | w_skip;

    // Resolve the single action for the next edge; reset and stall force HOLD
    always_comb begin
        w_act = ACT_HOLD;
        if (!rst_n || bus.stall) begin
            w_act = ACT_HOLD;
        end else if (w_clr_req) begin
            w_act = ACT_CLR;
        end else if (w_load_req) begin
            w_act = ACT_LOAD;
        end else if (w_inr_req) begin
            w_act = ACT_INR;
        end
    end

    // PC register; increment wraps naturally at the top of the address space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VEC;
        end else begin
            case (w_act)
                ACT_CLR:  r_pc <= '0;
                ACT_LOAD: r_pc <= bus.ar;
                ACT_INR:  r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                default:  r_pc <= r_pc;
            endcase
        end
    end

    assign bus.pc      = r_pc;
`ifdef PC_UNIT_INTR_EN
    assign bus.pc_clr  = (w_act == ACT_CLR);
`else
    assign bus.pc_clr  = 1'b0;
`endif
    assign bus.pc_load = (w_act == ACT_LOAD);
    assign bus.pc_inr  = (w_act == ACT_INR);
endmodule
